// File: rtl/if_id_buf_pkg.sv
// Shared constants and helpers for the fetch/decode skid buffer.
// Imported by if_id_buf.
package if_id_buf_pkg;

    localparam int          IF_ID_XLEN  = 32;
    localparam int          IF_ID_DEPTH = 2;
    localparam int          CNT_W       = 2;
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;

    // Occupancy after one cycle of push/pop (simultaneous push+pop holds).
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] count,
        input logic             push,
        input logic             pop
    );
        logic [CNT_W-1:0] res;
        res = count;
        unique case ({push, pop})
            2'b10:   res = count + CNT_W'(1);
            2'b01:   res = count - CNT_W'(1);
            default: res = count;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/if_id_buf.sv
// 2-entry skid FIFO between fetch and decode.
// Ready signals depend on registered state only; redirects drop all entries.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int XLEN  = IF_ID_XLEN,
    parameter int DEPTH = IF_ID_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_inst,
    input  logic            if_exp_flag,
    output logic            if_ready,
    input  logic            bj_flag,
    input  logic            wb_exp_int_flag,
    input  logic            ex_is_mret_inst,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic            id_exp_flag
);

    logic             wr_ptr;
    logic             rd_ptr;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0]  mem_pc   [DEPTH];
    logic [XLEN-1:0]  mem_inst [DEPTH];
    logic             mem_exp  [DEPTH];

    logic flush;
    logic full;
    logic empty;
    logic push;
    logic pop;

    assign flush = bj_flag | wb_exp_int_flag | ex_is_mret_inst;
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Full blocks fetch even when decode pops this cycle: that is the skid slot.
    assign if_ready = ~full & ~rst;
    // Masking on flush keeps decode from consuming a stale head on redirect.
    assign id_valid = ~empty & ~flush & ~rst;

    assign push = if_valid & if_ready & ~flush;
    assign pop  = id_valid & id_ready;

    // Pointer and occupancy state; flush realigns read onto write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= next_count(count, push, pop);
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= if_pc;
            mem_inst[wr_ptr] <= if_inst;
            mem_exp[wr_ptr]  <= if_exp_flag;
        end
    end

    // Present the head entry, or a canonical NOP bubble when nothing is valid.
    always_comb begin
        id_pc       = '0;
        id_inst     = XLEN'(INST_NOP);
        id_exp_flag = 1'b0;
        if (id_valid) begin
            id_pc       = mem_pc[rd_ptr];
            id_inst     = mem_inst[rd_ptr];
            id_exp_flag = mem_exp[rd_ptr];
        end
    end

endmodule
